// File: rtl/sync_arith_arbiter_if.sv
// Requester, arithmetic-unit and response signals of the round-robin arithmetic arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface sync_arith_arbiter_if #(
  parameter int unsigned BITS  = 32,
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]      i_req_valid;
  logic [N_REQ-1:0]      o_req_ready;
  logic [N_REQ*BITS-1:0] i_req_arg_A;
  logic [N_REQ*BITS-1:0] i_req_arg_B;
  logic [N_REQ*2-1:0]    i_req_op;
  logic [BITS-1:0]       o_alu_arg_A;
  logic [BITS-1:0]       o_alu_arg_B;
  logic [1:0]            o_alu_op;
  logic [BITS-1:0]       i_alu_result;
  logic [3:0]            i_alu_status;
  logic [N_REQ-1:0]      o_rsp_valid;
  logic [BITS-1:0]       o_rsp_result;
  logic [3:0]            o_rsp_status;
  logic                  i_rsp_ready;
  logic                  o_busy;

  modport slave (
    input  i_req_valid, i_req_arg_A, i_req_arg_B, i_req_op,
    input  i_alu_result, i_alu_status, i_rsp_ready,
    output o_req_ready, o_alu_arg_A, o_alu_arg_B, o_alu_op,
    output o_rsp_valid, o_rsp_result, o_rsp_status, o_busy
  );

  modport master (
    output i_req_valid, i_req_arg_A, i_req_arg_B, i_req_op,
    output i_alu_result, i_alu_status, i_rsp_ready,
    input  o_req_ready, o_alu_arg_A, o_alu_arg_B, o_alu_op,
    input  o_rsp_valid, o_rsp_result, o_rsp_status, o_busy
  );
endinterface

// File: rtl/sync_arith_arbiter.sv
// Round-robin arbiter sharing one fixed-latency arithmetic unit among N_REQ requesters,
// with exactly one transaction in flight and a one-hot response to the owning requester.
module sync_arith_arbiter #(
  parameter int unsigned BITS    = 32,
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input logic                 i_clk,
  input logic                 i_reset,
  sync_arith_arbiter_if.slave bus
);
  localparam int unsigned   PtrW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned   CntW    = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [PtrW:0] LastIdx = (PtrW + 1)'(N_REQ - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   owner_q, owner_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0]   alu_a_q, alu_a_d;
  logic [BITS-1:0]   alu_b_q, alu_b_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [BITS-1:0]   result_q, result_d;
  logic [3:0]        status_q, status_d;
  logic [N_REQ-1:0]  req_ready;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic               gnt_found;
  logic [PtrW-1:0]    gnt_off;
  logic [PtrW:0]      gnt_sum;
  logic [PtrW-1:0]    gnt_idx;

  // Rotate requests so bit 0 is the requester at rr_ptr; first set bit is the grant offset.
  assign req_dbl = {bus.i_req_valid, bus.i_req_valid} >> rr_ptr_q;
  assign req_rot = req_dbl[N_REQ-1:0];

  always_comb begin
    gnt_found = 1'b0;
    gnt_off   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req_rot[i]) begin
        gnt_found = 1'b1;
        gnt_off   = PtrW'(i);
      end
    end
  end

  assign gnt_sum = {1'b0, rr_ptr_q} + {1'b0, gnt_off};
  assign gnt_idx = (gnt_sum > LastIdx) ? PtrW'(gnt_sum - (LastIdx + 1'b1)) : gnt_sum[PtrW-1:0];

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    result_d  = result_q;
    status_d  = status_q;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          req_ready = N_REQ'(1) << gnt_idx;
          owner_d   = gnt_idx;
          alu_a_d   = bus.i_req_arg_A[gnt_idx*BITS +: BITS];
          alu_b_d   = bus.i_req_arg_B[gnt_idx*BITS +: BITS];
          alu_op_d  = bus.i_req_op[gnt_idx*2 +: 2];
          cnt_d     = CntW'(ALU_LAT);
          state_d   = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          result_d = bus.i_alu_result;
          status_d = bus.i_alu_status;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (bus.i_rsp_ready) begin
          state_d  = StIdle;
          rr_ptr_d = ({1'b0, owner_q} == LastIdx) ? '0 : PtrW'(owner_q + 1'b1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  // Grant is combinational from IDLE state, so it must be masked while reset is applied.
  assign bus.o_req_ready  = i_reset ? '0 : req_ready;
  assign bus.o_alu_arg_A  = alu_a_q;
  assign bus.o_alu_arg_B  = alu_b_q;
  assign bus.o_alu_op     = alu_op_q;
  assign bus.o_rsp_valid  = (state_q == StResp) ? (N_REQ'(1) << owner_q) : '0;
  assign bus.o_rsp_result = result_q;
  assign bus.o_rsp_status = status_q;
  assign bus.o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_sync_arith_arbiter.sv
// Randomized bench for sync_arith_arbiter: an arithmetic-unit stub plus a transaction-level
// round-robin and arithmetic reference model predict every grant, operand and response.
module tb_sync_arith_arbiter;
  localparam int unsigned BITS    = 32;
  localparam int unsigned N_REQ   = 4;
  localparam int unsigned ALU_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_arith_arbiter_if #(.BITS(BITS), .N_REQ(N_REQ)) bus ();

  sync_arith_arbiter #(.BITS(BITS), .N_REQ(N_REQ), .ALU_LAT(ALU_LAT)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int rr_m     = 0;
  logic [BITS-1:0] a_v  [N_REQ];
  logic [BITS-1:0] b_v  [N_REQ];
  logic [1:0]      op_v [N_REQ];

  // Status = {negative, zero, carry/borrow, overflow}; ops: add, sub, and, xor.
  function automatic logic [BITS+3:0] alu_fn(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                                             input logic [1:0] op);
    logic [BITS:0]   wide;
    logic [BITS-1:0] r;
    logic            c;
    logic            v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[BITS-1:0];
        c    = wide[BITS];
        v    = (a[BITS-1] == b[BITS-1]) && (r[BITS-1] != a[BITS-1]);
      end
      2'd1: begin
        wide = {1'b0, a} - {1'b0, b};
        r    = wide[BITS-1:0];
        c    = wide[BITS];
        v    = (a[BITS-1] != b[BITS-1]) && (r[BITS-1] != a[BITS-1]);
      end
      2'd2:    r = a & b;
      default: r = a ^ b;
    endcase
    return {r[BITS-1], (r == '0), c, v, r};
  endfunction

  logic [BITS+3:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_fn(bus.o_alu_arg_A, bus.o_alu_arg_B, bus.o_alu_op);
    for (int s = 1; s < ALU_LAT; s++) alu_pipe[s] <= alu_pipe[s-1];
  end
  assign bus.i_alu_result = alu_pipe[ALU_LAT-1][BITS-1:0];
  assign bus.i_alu_status = alu_pipe[ALU_LAT-1][BITS+3:BITS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input logic [N_REQ-1:0] m);
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (rr_m + k) % N_REQ;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic drive_args();
    for (int k = 0; k < N_REQ; k++) begin
      bus.i_req_arg_A[k*BITS +: BITS] = a_v[k];
      bus.i_req_arg_B[k*BITS +: BITS] = b_v[k];
      bus.i_req_op[k*2 +: 2]          = op_v[k];
    end
  endtask

  task automatic rand_args();
    for (int k = 0; k < N_REQ; k++) begin
      a_v[k]  = BITS'($urandom());
      b_v[k]  = BITS'($urandom());
      op_v[k] = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at #1 after a rising edge with the DUT idle; returns likewise.
  task automatic run_txn(input logic [N_REQ-1:0] mask, input int hold);
    int               g;
    logic [N_REQ-1:0] oh;
    logic [BITS+3:0]  exp_rs;
    logic [BITS-1:0]  ea;
    logic [BITS-1:0]  eb;
    logic [1:0]       eo;
    drive_args();
    bus.i_req_valid = mask;
    bus.i_rsp_ready = (hold == 0);
    g = model_grant(mask);
    @(negedge clk);
    check("busy_idle", 64'(bus.o_busy), 64'(0));
    if (g < 0) begin
      check("ready_none", 64'(bus.o_req_ready), 64'(0));
      tick();
      return;
    end
    oh     = N_REQ'(1) << g;
    ea     = a_v[g];
    eb     = b_v[g];
    eo     = op_v[g];
    exp_rs = alu_fn(ea, eb, eo);
    check("ready_grant", 64'(bus.o_req_ready), 64'(oh));
    tick();
    rand_args();
    drive_args();
    @(negedge clk);
    check("alu_a", 64'(bus.o_alu_arg_A), 64'(ea));
    check("alu_b", 64'(bus.o_alu_arg_B), 64'(eb));
    check("alu_op", 64'(bus.o_alu_op), 64'(eo));
    check("busy_wait", 64'(bus.o_busy), 64'(1));
    check("ready_wait", 64'(bus.o_req_ready), 64'(0));
    check("rsp_early", 64'(bus.o_rsp_valid), 64'(0));
    for (int c = 0; c < ALU_LAT; c++) begin
      tick();
      @(negedge clk);
      check("rsp_early", 64'(bus.o_rsp_valid), 64'(0));
      check("alu_a_hold", 64'(bus.o_alu_arg_A), 64'(ea));
    end
    tick();
    @(negedge clk);
    check("rsp_valid", 64'(bus.o_rsp_valid), 64'(oh));
    check("rsp_result", 64'(bus.o_rsp_result), 64'(exp_rs[BITS-1:0]));
    check("rsp_status", 64'(bus.o_rsp_status), 64'(exp_rs[BITS+3:BITS]));
    check("ready_resp", 64'(bus.o_req_ready), 64'(0));
    if (hold > 0) begin
      for (int h = 1; h <= hold; h++) begin
        tick();
        if (h == hold) bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        check("hold_valid", 64'(bus.o_rsp_valid), 64'(oh));
        check("hold_result", 64'(bus.o_rsp_result), 64'(exp_rs[BITS-1:0]));
        check("hold_status", 64'(bus.o_rsp_status), 64'(exp_rs[BITS+3:BITS]));
        check("hold_ready", 64'(bus.o_req_ready), 64'(0));
      end
    end
    tick();
    rr_m            = (g + 1) % N_REQ;
    bus.i_req_valid = '0;
    bus.i_rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_REQ-1:0] m;
    int               g;
    rand_args();
    drive_args();
    bus.i_req_valid = '1;
    bus.i_rsp_ready = 1'b0;
    rst             = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(bus.o_req_ready), 64'(0));
    check("rst_busy", 64'(bus.o_busy), 64'(0));
    check("rst_alu_a", 64'(bus.o_alu_arg_A), 64'(0));
    check("rst_alu_b", 64'(bus.o_alu_arg_B), 64'(0));
    check("rst_alu_op", 64'(bus.o_alu_op), 64'(0));
    check("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'(0));
    check("rst_result", 64'(bus.o_rsp_result), 64'(0));
    check("rst_status", 64'(bus.o_rsp_status), 64'(0));
    tick();
    rst             = 1'b0;
    bus.i_req_valid = '0;
    rr_m            = 0;

    // All four continuously valid: grants 0,1,2,3,0.
    for (int t = 0; t < 5; t++) begin
      rand_args();
      check("rr_order", 64'(model_grant('1)), 64'(t % N_REQ));
      run_txn('1, 0);
    end

    // Single request from requester 2.
    rand_args();
    a_v[2]  = BITS'(7);
    b_v[2]  = BITS'(5);
    op_v[2] = 2'd0;
    run_txn(4'b0100, 0);

    // Wrap: grant 3, then 0 and 2 valid -> 0 then 2.
    rand_args();
    run_txn(4'b1000, 0);
    rand_args();
    run_txn(4'b0101, 0);
    rand_args();
    run_txn(4'b0101, 0);

    // Backpressure for 5 cycles in RESP.
    rand_args();
    run_txn(4'b0010, 5);

    // Reset during WAIT abandons the transaction and clears the pointer.
    rand_args();
    drive_args();
    m               = 4'b0110;
    g               = model_grant(m);
    bus.i_req_valid = m;
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    check("rstw_grant", 64'(bus.o_req_ready), 64'(N_REQ'(1) << g));
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rstw_ready", 64'(bus.o_req_ready), 64'(0));
    tick();
    rst             = 1'b0;
    bus.i_req_valid = '0;
    @(negedge clk);
    check("rstw_busy", 64'(bus.o_busy), 64'(0));
    check("rstw_alu_a", 64'(bus.o_alu_arg_A), 64'(0));
    check("rstw_alu_b", 64'(bus.o_alu_arg_B), 64'(0));
    check("rstw_alu_op", 64'(bus.o_alu_op), 64'(0));
    check("rstw_rsp_valid", 64'(bus.o_rsp_valid), 64'(0));
    check("rstw_result", 64'(bus.o_rsp_result), 64'(0));
    check("rstw_status", 64'(bus.o_rsp_status), 64'(0));
    tick();
    @(negedge clk);
    check("rstw_late_rsp", 64'(bus.o_rsp_valid), 64'(0));
    tick();
    rr_m = 0;
    rand_args();
    run_txn('1, 0);

    // Random transactions, occasionally interleaved with empty idle cycles.
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 7) == 0) run_txn('0, 0);
      rand_args();
      m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      run_txn(m, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_arith_arbiter.md
SYNC_ARITH_ARBITER -- requirements
Module: sync_arith_arbiter

Interface
REQ-001 Parameter BITS, default 32, operand/result width; matches the shared arithmetic unit.
REQ-002 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-003 Parameter ALU_LAT, default 1, clock cycles from arithmetic-unit input sample to o_result/o_status valid.
REQ-004 i_clk  in  1  single clock, all state updates on rising edge.
REQ-005 i_reset  in  1  synchronous, active-high reset.
REQ-006 i_req_valid  in  N_REQ  per-requester request valid.
REQ-007 o_req_ready  out  N_REQ  per-requester accept; at most one bit high.
REQ-008 i_req_arg_A  in  N_REQ*BITS  operand A, requester k in bits [k*BITS +: BITS].
REQ-009 i_req_arg_B  in  N_REQ*BITS  operand B, same packing.
REQ-010 i_req_op  in  N_REQ*2  opcode, requester k in bits [k*2 +: 2].
REQ-011 o_alu_arg_A, o_alu_arg_B  out  BITS each  registered operands to the arithmetic unit.
REQ-012 o_alu_op  out  2  registered opcode to the arithmetic unit.
REQ-013 i_alu_result  in  BITS; i_alu_status  in  4  outputs of the arithmetic unit.
REQ-014 o_rsp_valid  out  N_REQ  one-hot response valid, bit = owning requester.
REQ-015 o_rsp_result  out  BITS; o_rsp_status  out  4  captured result and status.
REQ-016 i_rsp_ready  in  1  response consumed by the owner.
REQ-017 o_busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, WAIT, RESP; exactly one transaction in flight.
REQ-019 IDLE: grant g = first k with i_req_valid[k]=1 searching from rr_ptr upward, wrapping N_REQ-1 -> 0.
REQ-020 IDLE with any valid: o_req_ready[g]=1 combinationally that cycle; transfer occurs; FSM -> WAIT.
REQ-021 o_req_ready is all-zero in WAIT, RESP and in IDLE with no valid request.
REQ-022 On transfer edge: o_alu_arg_A/B/op load requester g's fields; hold stable until next transfer; op passed unmodified (all 4 codes).
REQ-023 WAIT lasts exactly ALU_LAT+1 cycles (down-counter); at the edge ending the last WAIT cycle, i_alu_result/i_alu_status captured into o_rsp_result/o_rsp_status; FSM -> RESP.
REQ-024 Latency: transfer in cycle T -> o_rsp_valid high from cycle T+ALU_LAT+2 (T+3 at default).
REQ-025 RESP: o_rsp_valid[g]=1, result/status stable; when i_rsp_ready=1, FSM -> IDLE next edge, rr_ptr <= (g+1) mod N_REQ.
REQ-026 i_rsp_ready is ignored outside RESP; no new grant while in RESP, even if i_rsp_ready is high in the same cycle.
REQ-027 A requester dropping i_req_valid before grant loses no state; a re-request is treated as new.
REQ-028 Round robin guarantees: a continuously valid requester is granted within N_REQ transactions.
REQ-029 rr_ptr wraps N_REQ-1 -> 0; no ptr change in IDLE without grant.

Reset
REQ-030 While i_reset=1 at a rising edge: FSM -> IDLE, rr_ptr=0, WAIT counter=0.
REQ-031 Reset values: o_alu_arg_A=0, o_alu_arg_B=0, o_alu_op=0, o_rsp_valid=0, o_rsp_result=0, o_rsp_status=0, o_busy=0; o_req_ready=0 while i_reset=1.
REQ-032 Reset mid-transaction (WAIT or RESP) abandons it; no response issued; late i_alu_result ignored.

Verification
REQ-033 Single request: req 2, A=7, B=5, op=0, rsp_ready=1 -> ready[2] cycle T, o_alu_* = 7/5/0 at T+1, rsp_valid=4'b0100 at T+3 with the unit's result/status.
REQ-034 All four valid continuously -> grants 0,1,2,3,0 in order, one accepted per transaction, never two ready bits high.
REQ-035 Backpressure: i_rsp_ready low 5 cycles in RESP -> rsp_valid, result, status held unchanged; no ready asserted until release.
REQ-036 Wrap: after grant to 3, requesters 0 and 2 valid -> 0 granted first, then 2.
REQ-037 Reset asserted during WAIT -> next cycle o_busy=0, all outputs zero, no rsp_valid; next request granted from requester 0.
REQ-038 Random: 80 random A/B/op transactions over random requesters, compared against a reference model of the arithmetic unit -> zero mismatches, response always to the requester that issued it.
